// File: rtl/apb_master_pkg.sv
// Shared types and constants for the request/grant to APB3 master bridge.
//   apb_mst_state_e   : bridge FSM state encoding (IDLE/SETUP/ACCESS)
//   APB_TIMEOUT_RDATA : read data returned when a transfer is aborted by timeout
//   cnt_width()       : width of a saturating counter that must reach a given max
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Bits needed to hold 0..max, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max);
        int unsigned w;
        w = $clog2(max + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_bus.sv
// APB3 bus bundle.
//   Master modport : drives paddr/pwdata/pwrite/psel/penable, receives prdata/pready/pslverr
//   Slave modport  : the mirror image
interface APB_BUS #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter for the APB ACCESS phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear count to zero (has priority over en)
//   en         : count one more stalled cycle
//   hit        : count has reached MAX; constant 0 when MAX = 0
module apb_timeout_cnt
    import apb_master_pkg::*;
#(
    parameter int unsigned MAX = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned CNT_W = cnt_width(MAX);

    logic [CNT_W-1:0] r_cnt;

    // Counter is held at zero when the timeout is disabled; it stops at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (MAX == 0)) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != CNT_W'(MAX))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign hit = (MAX != 0) && (r_cnt == CNT_W'(MAX));

endmodule

// File: rtl/apb_req_master.sv
// Request/grant (req/gnt/rvalid) to APB3 master bridge with wait-state timeout.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_i/addr_i/we_i/wdata_i : transfer request and its payload
//   gnt_o               : request accepted this cycle (combinational, IDLE only)
//   rvalid_o            : one-cycle response strobe
//   rdata_o/err_o/timeout_o   : registered response, held until the next response
//   apb_master          : APB3 master port
module apb_req_master
    import apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      timeout_o,
    APB_BUS.Master                    apb_master
);

    apb_mst_state_e            r_state;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_rvalid;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;
    logic                      r_timeout;

    logic w_gnt;
    logic w_in_access;
    logic w_done;
    logic w_hit;

    // Grant is masked by reset so nothing is accepted while the block is held.
    assign w_gnt       = rst_n & req_i & (r_state == IDLE);
    assign w_in_access = (r_state == ACCESS);
    assign w_done      = w_in_access & apb_master.pready;

    apb_timeout_cnt #(
        .MAX (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_gnt | w_done),
        .en    (w_in_access & ~apb_master.pready),
        .hit   (w_hit)
    );

    // Bridge FSM; every APB and response output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_paddr  <= addr_i;
                        r_pwdata <= wdata_i;
                        r_pwrite <= we_i;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // pready is checked first so it beats a same-cycle timeout.
                    if (apb_master.pready) begin
                        r_rdata   <= r_pwrite ? '0 : apb_master.prdata;
                        r_err     <= apb_master.pslverr;
                        r_timeout <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_hit) begin
                        r_rdata   <= APB_DATA_WIDTH'(APB_TIMEOUT_RDATA);
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_rvalid  <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = w_gnt;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;
    assign err_o     = r_err;
    assign timeout_o = r_timeout;

    assign apb_master.paddr   = r_paddr;
    assign apb_master.pwdata  = r_pwdata;
    assign apb_master.pwrite  = r_pwrite;
    assign apb_master.psel    = r_psel;
    assign apb_master.penable = r_penable;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: directed transfers, responses checked by a
// scoreboard monitor that pops the expected response on every rvalid_o.
module tb_apb_req_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          req0;
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          gnt, rvalid, err, tmo;
    logic [31:0]   rdata;
    logic          gnt0, rvalid0, err0, tmo0;
    logic [31:0]   rdata0;

    always #5 clk = ~clk;

    APB_BUS #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus8 ();
    APB_BUS #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus0 ();

    apb_req_master #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .addr_i     (addr),
        .we_i       (we),
        .wdata_i    (wdata),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .err_o      (err),
        .timeout_o  (tmo),
        .apb_master (bus8)
    );

    apb_req_master #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (0)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req0),
        .addr_i     (addr),
        .we_i       (we),
        .wdata_i    (wdata),
        .gnt_o      (gnt0),
        .rvalid_o   (rvalid0),
        .rdata_o    (rdata0),
        .err_o      (err0),
        .timeout_o  (tmo0),
        .apb_master (bus0)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every response strobe must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rvalid", 96'(1), 96'(0));
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rsp_cycle", 96'(cyc), 96'(mon_e.cyc));
                    chk("rsp_rdata", 96'(rdata), 96'(mon_e.rdata));
                    chk("rsp_err", 96'(err), 96'(mon_e.err));
                    chk("rsp_timeout", 96'(tmo), 96'(mon_e.tmo));
                    chk("rsp_psel_pen", 96'({bus8.psel, bus8.penable}), 96'(0));
                end
            end
        end
    end

    // One transfer on dut; called at a negedge, returns at the response-cycle negedge.
    // waits < 0 means the slave never answers.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int waits, input logic [31:0] prd, input logic serr,
                        output int t_gnt);
        exp_t e;
        req = 1'b1; addr = a; we = w; wdata = wd;
        #1;
        chk("gnt", 96'(gnt), 96'(1));
        t_gnt   = cyc;
        e.rdata = (waits < 0) ? 32'hDEAD_BEEF : (w ? 32'h0 : prd);
        e.err   = (waits < 0) ? 1'b1 : serr;
        e.tmo   = (waits < 0);
        e.cyc   = cyc + 3 + ((waits < 0) ? int'(TO) : waits);
        sbq.push_back(e);
        @(negedge clk);
        req = 1'b0; addr = ~a; wdata = ~wd; we = ~w;
        chk("setup", 96'({bus8.psel, bus8.penable}), 96'(2'b10));
        req = 1'b1;
        #1;
        chk("gnt_busy", 96'(gnt), 96'(0));
        req = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("access", 96'({bus8.psel, bus8.penable}), 96'(2'b11));
            chk("hold", 96'({bus8.paddr, bus8.pwdata, bus8.pwrite}), 96'({a, wd, w}));
            if (k == waits) begin
                bus8.pready  = 1'b1;
                bus8.prdata  = w ? 32'hBAD0_BAD0 : prd;
                bus8.pslverr = serr;
                break;
            end
            if (waits < 0 && k == int'(TO)) break;
            bus8.pready  = 1'b0;
            bus8.prdata  = 32'hCAFE_F00D;
            bus8.pslverr = 1'b1;
        end
        @(negedge clk);
        bus8.pready = 1'b0; bus8.pslverr = 1'b0; bus8.prdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int t1, t2, t3, seen;

    initial begin
        rst_n = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        bus8.pready = 1'b0; bus8.prdata = '0; bus8.pslverr = 1'b0;
        bus0.pready = 1'b0; bus0.prdata = '0; bus0.pslverr = 1'b0;
        repeat (2) @(negedge clk);
        req = 1'b1;
        #1;
        chk("gnt_in_reset", 96'(gnt), 96'(0));
        req = 1'b0;
        chk("rst_ctrl", 96'({bus8.psel, bus8.penable, bus8.pwrite}), 96'(0));
        chk("rst_paddr", 96'(bus8.paddr), 96'(0));
        chk("rst_pwdata", 96'(bus8.pwdata), 96'(0));
        chk("rst_rsp", 96'({rvalid, rdata, err, tmo}), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait read, 4-wait write, slave error
        xfer(32'h1A10_1000, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0, t1);
        @(negedge clk);
        xfer(32'h1A10_3004, 1'b1, 32'hA5A5_0001, 4, 32'h0, 1'b0, t1);
        @(negedge clk);
        xfer(32'h1A10_2008, 1'b0, 32'h0, 1, 32'h0000_00E5, 1'b1, t1);
        @(negedge clk);
        @(negedge clk);
        chk("rsp_hold", 96'({rdata, err, tmo}), 96'({32'h0000_00E5, 1'b1, 1'b0}));

        // timeout, then a late pready that must be ignored
        xfer(32'h1A10_4000, 1'b0, 32'h0, -1, 32'h0, 1'b0, t1);
        bus8.pready = 1'b1; bus8.prdata = 32'h1111_2222;
        @(negedge clk);
        bus8.pready = 1'b0; bus8.prdata = 32'h0;
        chk("late_pready_state", 96'({bus8.psel, bus8.penable}), 96'(0));
        @(negedge clk);

        // pready on the 8th ACCESS cycle, and on the cycle the timeout hits
        xfer(32'h1A10_5000, 1'b0, 32'h0, 7, 32'h0BAD_CAFE, 1'b0, t1);
        @(negedge clk);
        xfer(32'h1A10_5004, 1'b0, 32'h0, 8, 32'h600D_0008, 1'b0, t1);
        @(negedge clk);

        // back-to-back with req_i dropped on each grant
        xfer(32'h1A10_6000, 1'b0, 32'h0, 0, 32'h0000_0001, 1'b0, t1);
        xfer(32'h1A10_6004, 1'b1, 32'h0000_0002, 0, 32'h0, 1'b0, t2);
        xfer(32'h1A10_6008, 1'b0, 32'h0, 0, 32'h0000_0003, 1'b0, t3);
        chk("b2b_gap1", 96'(t2 - t1), 96'(3));
        chk("b2b_gap2", 96'(t3 - t2), 96'(3));
        @(negedge clk);

        // reset during the 2nd ACCESS cycle: no response for the lost transfer
        req = 1'b1; addr = 32'h1A10_7000; we = 1'b1; wdata = 32'h7777_7777;
        #1;
        chk("gnt_pre_rst", 96'(gnt), 96'(1));
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("access2", 96'({bus8.psel, bus8.penable}), 96'(2'b11));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 96'({bus8.psel, bus8.penable, bus8.pwrite}), 96'(0));
        chk("rst_mid_bus", 96'({bus8.paddr, bus8.pwdata}), 96'(0));
        chk("rst_mid_rsp", 96'({rvalid, rdata, err, tmo}), 96'(0));
        req = 1'b1;
        #1;
        chk("gnt_mid_rst", 96'(gnt), 96'(0));
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        xfer(32'h1A10_8000, 1'b0, 32'h0, 2, 32'h8888_0001, 1'b0, t1);
        @(negedge clk);

        // timeout disabled: ACCESS waits indefinitely
        req0 = 1'b1; addr = 32'h1A10_9000; we = 1'b0;
        #1;
        chk("gnt0", 96'(gnt0), 96'(1));
        @(negedge clk);
        req0 = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rvalid0 === 1'b1) seen++;
        end
        chk("no_timeout_rvalid", 96'(seen), 96'(0));
        chk("no_timeout_access", 96'({bus0.psel, bus0.penable}), 96'(2'b11));
        bus0.pready = 1'b1; bus0.prdata = 32'h7777_0000;
        @(negedge clk);
        bus0.pready = 1'b0;
        chk("no_timeout_rsp", 96'({rvalid0, rdata0, err0, tmo0}), 96'({1'b1, 32'h7777_0000, 1'b0, 1'b0}));

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 96'(sbq.size()), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
